zx_keymatrix: RTL and testbench
===============================

# zx_keymatrix

PS/2 keyboard front end for the ZX Spectrum core. It deserialises set-2 scan codes from the MIST PS/2 lines and maintains the 8×5 Spectrum key matrix. It answers ULA port reads via `key_data` and exports function-key and modifier levels (`Fn`, `mod`) to the top level for turbo, tape and reset control. It directly feeds the top level's `cpu_din` mux, turbo logic and reset logic.

## Interface
- `FILTER_LEN`, default 8: consecutive equal PS/2 clock samples needed to accept a new level.
- `TIMEOUT`, default 56000: clk_sys cycles without a falling edge before a partial frame is dropped.
- `clk_sys` in 1: system clock.
- `reset` in 1: synchronous, active-high. Clock is `clk_sys`.
- `ps2_kbd_clk` in 1: asynchronous PS/2 clock.
- `ps2_kbd_data` in 1: asynchronous PS/2 data.
- `addr` in 16: CPU address. Only `addr[15:8]` (row select, active-low) is used.
- `key_data` out 5: active-low column bits for the selected rows (combinational from the registered matrix).
- `Fn` out 11 (`[11:1]`): F1..F11 held levels, 1 = pressed.
- `mod` out 3: {Shift, Alt, Ctrl} held levels. `mod[0]` is Ctrl, `mod[1]` is Alt, `mod[2]` is Shift.

## Operation
- **Sync:** 2-FF synchroniser on both PS/2 lines.
  - The filtered clock changes only after `FILTER_LEN` identical samples.
  - A falling edge is filtered 1→0.
- **Receiver:** samples data on each falling edge into an 11-bit shift register (LSB first) with a bit counter of 0..10.
  - On bit 10 the frame is checked: start=0, stop=1, odd parity over data+parity.
  - Pass: one-cycle `rx_strobe` with `rx_byte`.
  - Fail: frame discarded silently.
  - The counter always returns to 0 after bit 10.
- **Timeout:** a counter clears on each falling edge. When it reaches `TIMEOUT` with bit counter ≠ 0, the bit counter is forced to 0.
- **Decoder FSM** (states IDLE, EXT, REL, EXT_REL, SKIP):
  - In IDLE: `E0`→EXT; `F0`→REL; `E1`→SKIP with 7 bytes to discard. Any other byte is a make in IDLE.
  - In EXT, `F0`→EXT_REL.
  - Any other byte in EXT, REL or EXT_REL applies make (EXT) or break (REL, EXT_REL), then returns to IDLE.
  - `E0` while in REL is treated as EXT_REL.
- **Matrix rows** (`addr` bit 8..15 → row 0..7), columns bit0..4:
  - Row 0: CAPS(`12`,`59`) Z`1A` X`22` C`21` V`2A`
  - Row 1: A`1C` S`1B` D`23` F`2B` G`34`
  - Row 2: Q`15` W`1D` E`24` R`2D` T`2C`
  - Row 3: 1`16` 2`1E` 3`26` 4`25` 5`2E`
  - Row 4: 0`45` 9`46` 8`3E` 7`3D` 6`36`
  - Row 5: P`4D` O`44` I`43` U`3C` Y`35`
  - Row 6: ENTER`5A`/`E0 5A` L`4B` K`42` J`3B` H`33`
  - Row 7: SPACE`29` SYM(`14`,`E0 14`) M`3A` N`31` B`32`
- **Composite keys** keep separate held flags, OR-ed into the matrix:
  - Backspace `66` = CAPS+0.
  - `E0 6B`/`E0 74`/`E0 75`/`E0 72` = CAPS+5/8/7/6.
  - Releasing a composite never clears a physically held CAPS or digit.
- **Fn:** F1`05` F2`06` F3`04` F4`0C` F5`03` F6`0B` F7`83` F8`0A` F9`01` F10`09` F11`78`.
- **mod:** Ctrl from `14`/`E0 14`; Alt from `11`/`E0 11`; Shift from `12`/`59`.
- **Key read:** `key_data[c] = ~|{ row_bit[r][c] & ~addr[8+r] }` over all r. With `addr[15:8]=FF` the output is `11111`.
- Unmapped codes change nothing; the FSM still returns to IDLE.

## Timing
- Matrix, `Fn` and `mod` update on the cycle after `rx_strobe`. `rx_strobe` asserts 1 cycle after the filtered falling edge of bit 10.
- `key_data` has zero-cycle latency from `addr` (combinational).
- Reset values: all matrix/composite/`Fn`/`mod` bits 0; `key_data`=`11111`; FSM=IDLE; bit counter=0; timeout counter=0.
- Reset mid-frame drops the partial frame. The next valid frame decodes normally.
- A byte completing on the same cycle as timeout expiry: the completed frame wins.

## Structure
- Package `zx_kbd_pkg`:
  - scan-code constants;
  - row/column index constants;
  - decoder state enum.
- Sub-module `ps2_rx`: sync, filter, shift, parity check, timeout; outputs `rx_strobe`, `rx_byte`.
- Top `zx_keymatrix`: decoder FSM, matrix registers, row-select read logic.

## Test plan
- Send `1C` with addr=`FDFE` → `key_data`=`11110`. Send `F0 1C` → `11111`.
- Frame `1C` with bad parity → no matrix change. A following valid `1A` at addr=`FEFE` → `11101`.
- Hold `12`, press then release `66` → at addr=`FEFE` bit0 stays 0; at addr=`EFFE` bit0 is 0 during the press, then 1.
- Send `E0 6B` → addr=`F7FE` gives `01111` and addr=`FEFE` gives `11110`. `E0 F0 6B` clears both.
- Send 4 bits, idle > `TIMEOUT`, then full `78` → `Fn[11]`=1. Send `F0 78` → 0.
- Press `14`, `11`, `12`, then assert reset → `mod`=0, `Fn`=0, and `key_data`=`11111` at addr=`0000`.

Source files
------------

// File: rtl/zx_kbd_pkg.sv
// zx_kbd_pkg: scan codes, matrix positions and decoder states for the Spectrum keyboard.
package zx_kbd_pkg;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_REL    = 8'hF0;
    localparam logic [7:0] SC_PAUSE  = 8'hE1;
    localparam logic [7:0] SC_BKSP   = 8'h66;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_RIGHT  = 8'h74;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_ALT    = 8'h11;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam int SKIP_BYTES = 7;
    localparam int KEY_ROWS   = 8;
    localparam int KEY_COLS   = 5;
    localparam int KEY_BITS   = KEY_ROWS * KEY_COLS;
    localparam logic [5:0] KEY_NONE = 6'd63;
    typedef enum logic [2:0] {ST_IDLE, ST_EXT, ST_REL, ST_EXT_REL, ST_SKIP} dec_state_t;
    function automatic logic [5:0] kpos(input int r, input int c);
        return 6'(r * KEY_COLS + c);
    endfunction
    localparam logic [5:0] KEY_CAPS = kpos(0, 0);
    localparam logic [5:0] KEY_0    = kpos(4, 0);
    localparam logic [5:0] KEY_5    = kpos(3, 4);
    localparam logic [5:0] KEY_6    = kpos(4, 4);
    localparam logic [5:0] KEY_7    = kpos(4, 3);
    localparam logic [5:0] KEY_8    = kpos(4, 2);
    function automatic logic [KEY_BITS-1:0] kbit(input logic [5:0] k);
        return (k == KEY_NONE) ? '0 : (KEY_BITS'(1) << k);
    endfunction
    // Only ENTER and SYM/CTRL accept an E0 prefix; other extended codes are not plain keys.
    function automatic logic [5:0] key_idx(input logic [7:0] code, input logic ext);
        logic [5:0] k;
        case (code)
            8'h12, 8'h59: k = kpos(0, 0);
            8'h1A: k = kpos(0, 1);
            8'h22: k = kpos(0, 2);
            8'h21: k = kpos(0, 3);
            8'h2A: k = kpos(0, 4);
            8'h1C: k = kpos(1, 0);
            8'h1B: k = kpos(1, 1);
            8'h23: k = kpos(1, 2);
            8'h2B: k = kpos(1, 3);
            8'h34: k = kpos(1, 4);
            8'h15: k = kpos(2, 0);
            8'h1D: k = kpos(2, 1);
            8'h24: k = kpos(2, 2);
            8'h2D: k = kpos(2, 3);
            8'h2C: k = kpos(2, 4);
            8'h16: k = kpos(3, 0);
            8'h1E: k = kpos(3, 1);
            8'h26: k = kpos(3, 2);
            8'h25: k = kpos(3, 3);
            8'h2E: k = kpos(3, 4);
            8'h45: k = kpos(4, 0);
            8'h46: k = kpos(4, 1);
            8'h3E: k = kpos(4, 2);
            8'h3D: k = kpos(4, 3);
            8'h36: k = kpos(4, 4);
            8'h4D: k = kpos(5, 0);
            8'h44: k = kpos(5, 1);
            8'h43: k = kpos(5, 2);
            8'h3C: k = kpos(5, 3);
            8'h35: k = kpos(5, 4);
            8'h5A: k = kpos(6, 0);
            8'h4B: k = kpos(6, 1);
            8'h42: k = kpos(6, 2);
            8'h3B: k = kpos(6, 3);
            8'h33: k = kpos(6, 4);
            8'h29: k = kpos(7, 0);
            8'h14: k = kpos(7, 1);
            8'h3A: k = kpos(7, 2);
            8'h31: k = kpos(7, 3);
            8'h32: k = kpos(7, 4);
            default: k = KEY_NONE;
        endcase
        return (ext && code != SC_ENTER && code != SC_CTRL) ? KEY_NONE : k;
    endfunction
    function automatic logic [10:0] fn_mask(input logic [7:0] code, input logic ext);
        logic [10:0] m;
        case (code)
            8'h05: m = 11'h001;
            8'h06: m = 11'h002;
            8'h04: m = 11'h004;
            8'h0C: m = 11'h008;
            8'h03: m = 11'h010;
            8'h0B: m = 11'h020;
            8'h83: m = 11'h040;
            8'h0A: m = 11'h080;
            8'h01: m = 11'h100;
            8'h09: m = 11'h200;
            8'h78: m = 11'h400;
            default: m = '0;
        endcase
        return ext ? '0 : m;
    endfunction
endpackage

// File: rtl/ps2_rx.sv
// ps2_rx: synchronises and glitch-filters the PS/2 lines and deframes checked bytes.
module ps2_rx #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 56000
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       rx_strobe,
    output logic [7:0] rx_byte
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [1:0]    r_clk_sync, r_dat_sync;
    logic [FW-1:0] r_filt_cnt;
    logic          r_clk_filt, r_clk_prev;
    logic [9:0]    r_shift;
    logic [3:0]    r_bitcnt;
    logic [TW-1:0] r_to_cnt;
    logic          w_fall, w_frame_ok;
    logic [10:0]   w_frame;
    assign w_fall     = r_clk_prev & ~r_clk_filt;
    assign w_frame    = {r_dat_sync[1], r_shift};
    assign w_frame_ok = ~w_frame[0] & w_frame[10] & ^w_frame[9:1];
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
            r_filt_cnt <= '0;
            r_clk_filt <= 1'b1;
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[0], ps2_clk};
            r_dat_sync <= {r_dat_sync[0], ps2_data};
            r_clk_prev <= r_clk_filt;
            if (r_clk_sync[1] == r_clk_filt) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
                r_clk_filt <= r_clk_sync[1];
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end
    end
    // A falling edge takes priority over timeout expiry in the same cycle.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_shift   <= '0;
            r_bitcnt  <= '0;
            r_to_cnt  <= '0;
            rx_strobe <= 1'b0;
            rx_byte   <= '0;
        end else begin
            rx_strobe <= 1'b0;
            if (w_fall) begin
                r_shift  <= w_frame[10:1];
                r_to_cnt <= '0;
                if (r_bitcnt == 4'd10) begin
                    r_bitcnt  <= '0;
                    rx_strobe <= w_frame_ok;
                    rx_byte   <= w_frame[8:1];
                end else begin
                    r_bitcnt <= r_bitcnt + 1'b1;
                end
            end else begin
                if (r_to_cnt != TW'(TIMEOUT))
                    r_to_cnt <= r_to_cnt + 1'b1;
                if (r_to_cnt == TW'(TIMEOUT) && r_bitcnt != '0)
                    r_bitcnt <= '0;
            end
        end
    end
endmodule

// File: rtl/zx_keymatrix.sv
// zx_keymatrix: decodes PS/2 set-2 codes into the Spectrum 8x5 matrix, F-keys and modifiers.
module zx_keymatrix
    import zx_kbd_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 56000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ps2_kbd_clk,
    input  logic        ps2_kbd_data,
    input  logic [15:0] addr,
    output logic [4:0]  key_data,
    output logic [11:1] Fn,
    output logic [2:0]  mod
);
    logic                w_strobe, w_apply, w_ext, w_press, w_unused;
    logic [7:0]          w_byte;
    dec_state_t          r_state, w_next;
    logic [2:0]          r_skip;
    logic [KEY_BITS-1:0] r_keys, w_key_mask, w_comp_keys, w_eff;
    logic [4:0]          r_comp, w_comp_mask;
    logic [10:0]         r_fn, w_fn_mask;
    logic [2:0]          r_mod, w_mod_mask;
    ps2_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) u_rx (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .ps2_clk  (ps2_kbd_clk),
        .ps2_data (ps2_kbd_data),
        .rx_strobe(w_strobe),
        .rx_byte  (w_byte)
    );
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_skip  <= '0;
        end else begin
            r_state <= w_next;
            if (w_strobe && r_state == ST_IDLE && w_byte == SC_PAUSE)
                r_skip <= 3'(SKIP_BYTES);
            else if (w_strobe && r_state == ST_SKIP)
                r_skip <= r_skip - 1'b1;
        end
    end
    always_comb begin
        w_next = r_state;
        if (w_strobe) begin
            case (r_state)
                ST_IDLE:    w_next = (w_byte == SC_EXT) ? ST_EXT : (w_byte == SC_REL) ? ST_REL :
                                     (w_byte == SC_PAUSE) ? ST_SKIP : ST_IDLE;
                ST_EXT:     w_next = (w_byte == SC_REL) ? ST_EXT_REL : ST_IDLE;
                ST_REL:     w_next = (w_byte == SC_EXT) ? ST_EXT_REL : ST_IDLE;
                ST_SKIP:    w_next = (r_skip == 3'd1) ? ST_IDLE : ST_SKIP;
                default:    w_next = ST_IDLE;
            endcase
        end
    end
    always_comb begin
        w_ext   = (r_state == ST_EXT) || (r_state == ST_EXT_REL);
        w_press = (r_state == ST_IDLE) || (r_state == ST_EXT);
        w_apply = w_strobe && (
            (r_state == ST_IDLE) ? !(w_byte == SC_EXT || w_byte == SC_REL || w_byte == SC_PAUSE) :
            (r_state == ST_EXT)  ? (w_byte != SC_REL) :
            (r_state == ST_REL)  ? (w_byte != SC_EXT) :
            (r_state == ST_EXT_REL));
        w_key_mask  = kbit(key_idx(w_byte, w_ext));
        w_fn_mask   = fn_mask(w_byte, w_ext);
        w_comp_mask = {w_ext && w_byte == SC_RIGHT, w_ext && w_byte == SC_UP,
                       w_ext && w_byte == SC_DOWN, w_ext && w_byte == SC_LEFT,
                       !w_ext && w_byte == SC_BKSP};
        w_mod_mask  = {!w_ext && (w_byte == SC_LSHIFT || w_byte == SC_RSHIFT),
                       w_byte == SC_ALT, w_byte == SC_CTRL};
    end
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_keys <= '0;
            r_comp <= '0;
            r_fn   <= '0;
            r_mod  <= '0;
        end else if (w_apply) begin
            r_keys <= w_press ? (r_keys | w_key_mask)  : (r_keys & ~w_key_mask);
            r_comp <= w_press ? (r_comp | w_comp_mask) : (r_comp & ~w_comp_mask);
            r_fn   <= w_press ? (r_fn | w_fn_mask)     : (r_fn & ~w_fn_mask);
            r_mod  <= w_press ? (r_mod | w_mod_mask)   : (r_mod & ~w_mod_mask);
        end
    end
    // Composite flags only add bits, so a physically held CAPS or digit survives their release.
    always_comb begin
        w_comp_keys = ({KEY_BITS{r_comp[0]}} & (kbit(KEY_CAPS) | kbit(KEY_0)))
                    | ({KEY_BITS{r_comp[1]}} & (kbit(KEY_CAPS) | kbit(KEY_5)))
                    | ({KEY_BITS{r_comp[2]}} & (kbit(KEY_CAPS) | kbit(KEY_6)))
                    | ({KEY_BITS{r_comp[3]}} & (kbit(KEY_CAPS) | kbit(KEY_7)))
                    | ({KEY_BITS{r_comp[4]}} & (kbit(KEY_CAPS) | kbit(KEY_8)));
        w_eff    = r_keys | w_comp_keys;
        key_data = 5'b11111;
        for (int r = 0; r < KEY_ROWS; r++)
            key_data = addr[8+r] ? key_data : (key_data & ~w_eff[r*KEY_COLS +: KEY_COLS]);
    end
    assign w_unused = ^addr[7:0];
    assign Fn       = r_fn;
    assign mod      = r_mod;
endmodule

// File: tb/tb_zx_keymatrix.sv
// tb_zx_keymatrix: directed PS/2 frames against hand-computed matrix, Fn and mod values.
module tb_zx_keymatrix;
    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ps2_kbd_clk = 1'b1;
    logic        ps2_kbd_data = 1'b1;
    logic [15:0] addr = 16'hFFFF;
    logic [4:0]  key_data;
    logic [11:1] Fn;
    logic [2:0]  mod;
    int n_checks = 0;
    int n_fail = 0;
    zx_keymatrix #(.FILTER_LEN(8), .TIMEOUT(2000)) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .ps2_kbd_clk (ps2_kbd_clk),
        .ps2_kbd_data(ps2_kbd_data),
        .addr        (addr),
        .key_data    (key_data),
        .Fn          (Fn),
        .mod         (mod)
    );
    always #5 clk_sys = ~clk_sys;
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_sys);
    endtask
    task automatic ps2_bit(input logic b);
        ps2_kbd_data = b;
        wait_cyc(20);
        ps2_kbd_clk = 1'b0;
        wait_cyc(20);
        ps2_kbd_clk = 1'b1;
    endtask
    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) ps2_bit(f[i]);
        ps2_kbd_data = 1'b1;
        wait_cyc(30);
    endtask
    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0);
    endtask
    task automatic rd(input logic [15:0] a);
        @(negedge clk_sys);
        addr = a;
        #1;
    endtask
    task automatic test_reset;
        wait_cyc(5);
        @(negedge clk_sys);
        reset = 1'b0;
        rd(16'h0000);
        n_checks++;
        if (key_data !== 5'b11111) begin n_fail++; $display("FAIL reset_key got=%b exp=%b", key_data, 5'b11111); end
        n_checks++;
        if (Fn !== 11'h000) begin n_fail++; $display("FAIL reset_fn got=%h exp=%h", Fn, 11'h000); end
        n_checks++;
        if (mod !== 3'b000) begin n_fail++; $display("FAIL reset_mod got=%b exp=%b", mod, 3'b000); end
    endtask
    task automatic test_make_break;
        send(8'h1C);
        rd(16'hFDFE);
        n_checks++;
        if (key_data !== 5'b11110) begin n_fail++; $display("FAIL make_a got=%b exp=%b", key_data, 5'b11110); end
        send(8'hF0); send(8'h1C);
        rd(16'hFDFE);
        n_checks++;
        if (key_data !== 5'b11111) begin n_fail++; $display("FAIL break_a got=%b exp=%b", key_data, 5'b11111); end
    endtask
    task automatic test_bad_parity;
        send_frame(8'h1C, 1'b1);
        rd(16'hFDFE);
        n_checks++;
        if (key_data !== 5'b11111) begin n_fail++; $display("FAIL bad_parity got=%b exp=%b", key_data, 5'b11111); end
        send(8'h1A);
        rd(16'hFEFE);
        n_checks++;
        if (key_data !== 5'b11101) begin n_fail++; $display("FAIL after_parity_z got=%b exp=%b", key_data, 5'b11101); end
        send(8'hF0); send(8'h1A);
    endtask
    task automatic test_backspace;
        send(8'h12);
        send(8'h66);
        rd(16'hFEFE);
        n_checks++;
        if (key_data[0] !== 1'b0) begin n_fail++; $display("FAIL bksp_caps got=%b exp=%b", key_data[0], 1'b0); end
        rd(16'hEFFE);
        n_checks++;
        if (key_data !== 5'b11110) begin n_fail++; $display("FAIL bksp_zero got=%b exp=%b", key_data, 5'b11110); end
        send(8'hF0); send(8'h66);
        rd(16'hFEFE);
        n_checks++;
        if (key_data[0] !== 1'b0) begin n_fail++; $display("FAIL bksp_rel_caps got=%b exp=%b", key_data[0], 1'b0); end
        rd(16'hEFFE);
        n_checks++;
        if (key_data !== 5'b11111) begin n_fail++; $display("FAIL bksp_rel_zero got=%b exp=%b", key_data, 5'b11111); end
        send(8'hF0); send(8'h12);
        rd(16'hFEFE);
        n_checks++;
        if (key_data !== 5'b11111) begin n_fail++; $display("FAIL shift_rel got=%b exp=%b", key_data, 5'b11111); end
    endtask
    task automatic test_cursor;
        send(8'hE0); send(8'h6B);
        rd(16'hF7FE);
        n_checks++;
        if (key_data !== 5'b01111) begin n_fail++; $display("FAIL left_five got=%b exp=%b", key_data, 5'b01111); end
        rd(16'hFEFE);
        n_checks++;
        if (key_data !== 5'b11110) begin n_fail++; $display("FAIL left_caps got=%b exp=%b", key_data, 5'b11110); end
        send(8'hE0); send(8'hF0); send(8'h6B);
        rd(16'hF7FE);
        n_checks++;
        if (key_data !== 5'b11111) begin n_fail++; $display("FAIL left_rel_five got=%b exp=%b", key_data, 5'b11111); end
        rd(16'hFEFE);
        n_checks++;
        if (key_data !== 5'b11111) begin n_fail++; $display("FAIL left_rel_caps got=%b exp=%b", key_data, 5'b11111); end
    endtask
    task automatic test_timeout;
        for (int i = 0; i < 4; i++) ps2_bit(1'b0);
        wait_cyc(2500);
        send(8'h78);
        @(negedge clk_sys);
        n_checks++;
        if (Fn !== 11'h400) begin n_fail++; $display("FAIL timeout_f11 got=%h exp=%h", Fn, 11'h400); end
        send(8'hF0); send(8'h78);
        @(negedge clk_sys);
        n_checks++;
        if (Fn !== 11'h000) begin n_fail++; $display("FAIL f11_rel got=%h exp=%h", Fn, 11'h000); end
    endtask
    task automatic test_pause_and_f7;
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        rd(16'h0000);
        n_checks++;
        if (key_data !== 5'b11111) begin n_fail++; $display("FAIL pause_key got=%b exp=%b", key_data, 5'b11111); end
        n_checks++;
        if (mod !== 3'b000) begin n_fail++; $display("FAIL pause_mod got=%b exp=%b", mod, 3'b000); end
        send(8'h83);
        @(negedge clk_sys);
        n_checks++;
        if (Fn !== 11'h040) begin n_fail++; $display("FAIL f7_make got=%h exp=%h", Fn, 11'h040); end
        send(8'hF0); send(8'h83);
        @(negedge clk_sys);
        n_checks++;
        if (Fn !== 11'h000) begin n_fail++; $display("FAIL f7_rel got=%h exp=%h", Fn, 11'h000); end
    endtask
    task automatic test_mod_reset;
        send(8'h14); send(8'h11); send(8'h12); send(8'h05);
        rd(16'h0000);
        n_checks++;
        if (mod !== 3'b111) begin n_fail++; $display("FAIL mod_held got=%b exp=%b", mod, 3'b111); end
        n_checks++;
        if (key_data !== 5'b11100) begin n_fail++; $display("FAIL caps_sym got=%b exp=%b", key_data, 5'b11100); end
        n_checks++;
        if (Fn !== 11'h001) begin n_fail++; $display("FAIL f1_held got=%h exp=%h", Fn, 11'h001); end
        reset = 1'b1;
        wait_cyc(2);
        @(negedge clk_sys);
        reset = 1'b0;
        rd(16'h0000);
        n_checks++;
        if (mod !== 3'b000) begin n_fail++; $display("FAIL reset_mod_clr got=%b exp=%b", mod, 3'b000); end
        n_checks++;
        if (Fn !== 11'h000) begin n_fail++; $display("FAIL reset_fn_clr got=%h exp=%h", Fn, 11'h000); end
        n_checks++;
        if (key_data !== 5'b11111) begin n_fail++; $display("FAIL reset_key_clr got=%b exp=%b", key_data, 5'b11111); end
    endtask
    task automatic test_reset_mid_frame;
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        @(negedge clk_sys);
        reset = 1'b1;
        wait_cyc(3);
        @(negedge clk_sys);
        reset = 1'b0;
        send(8'h1C);
        rd(16'hFDFE);
        n_checks++;
        if (key_data !== 5'b11110) begin n_fail++; $display("FAIL mid_reset_a got=%b exp=%b", key_data, 5'b11110); end
        send(8'hF0); send(8'h1C);
    endtask
    initial begin
        test_reset;
        test_make_break;
        test_bad_parity;
        test_backspace;
        test_cursor;
        test_timeout;
        test_pause_and_f7;
        test_mod_reset;
        test_reset_mid_frame;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
